// File: rtl/rxhexword.sv
// Parses "0x" + 8 hex digits + CR LF from a byte stream into a 32-bit word; o_stb/o_err pulse one clock after the final/offending byte.
// No backpressure: every i_stb byte is consumed on arrival; inter-byte stalls inside a frame abort after TIMEOUT clocks.
module rxhexword #(
  parameter bit          ACCEPT_UPPER = 1'b1,
  parameter logic [23:0] TIMEOUT      = 24'd0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stb,
  input  logic [7:0]  i_byte,
  output logic        o_stb,
  output logic [31:0] o_data,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT0,
    S_DIGITS,
    S_EXPECT_CR,
    S_EXPECT_LF
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_x  = 8'h78;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] sreg_q, sreg_d;
  logic [31:0] data_q, data_d;
  logic [23:0] tmo_q, tmo_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;

  logic        is_hex;
  logic [3:0]  nib;
  logic        x_ok;
  logic        tmo_hit;
  logic        fail;

  // ASCII letters a-f / A-F carry their value minus 9 in the low nibble.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      is_hex = 1'b1;
      nib    = i_byte[3:0];
    end else if (i_byte >= 8'h61 && i_byte <= 8'h66) begin
      is_hex = 1'b1;
      nib    = i_byte[3:0] + 4'd9;
    end else if (ACCEPT_UPPER && i_byte >= 8'h41 && i_byte <= 8'h46) begin
      is_hex = 1'b1;
      nib    = i_byte[3:0] + 4'd9;
    end
  end

  assign x_ok    = (i_byte == CH_x) || (ACCEPT_UPPER && (i_byte == CH_X));
  assign tmo_hit = (TIMEOUT != 24'd0) && (tmo_q == TIMEOUT - 24'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    tmo_d   = tmo_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    fail    = 1'b0;

    if (state_q == S_IDLE || i_stb) begin
      tmo_d = 24'd0;
    end else if (tmo_q != 24'hff_ffff) begin
      tmo_d = tmo_q + 24'd1;
    end

    if (i_stb) begin
      case (state_q)
        S_IDLE: begin
          if (i_byte == CH_0) state_d = S_GOT0;
        end
        S_GOT0: begin
          if (x_ok) begin
            state_d = S_DIGITS;
            cnt_d   = 3'd0;
            sreg_d  = 32'd0;
          end else if (i_byte != CH_0) begin
            fail = 1'b1;
          end
        end
        S_DIGITS: begin
          if (is_hex) begin
            sreg_d = {sreg_q[27:0], nib};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = S_EXPECT_CR;
          end else begin
            fail = 1'b1;
          end
        end
        S_EXPECT_CR: begin
          if (i_byte == CH_CR) state_d = S_EXPECT_LF;
          else                 fail    = 1'b1;
        end
        S_EXPECT_LF: begin
          if (i_byte == CH_LF) begin
            state_d = S_IDLE;
            data_d  = sreg_q;
            stb_d   = 1'b1;
            sreg_d  = 32'd0;
            cnt_d   = 3'd0;
          end else begin
            fail = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // A '0' that breaks a frame may itself start the next one.
      if (fail) begin
        err_d   = 1'b1;
        state_d = (i_byte == CH_0) ? S_GOT0 : S_IDLE;
        sreg_d  = 32'd0;
        cnt_d   = 3'd0;
      end
    end else if (state_q != S_IDLE && tmo_hit) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
      sreg_d  = 32'd0;
      cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      sreg_q  <= 32'd0;
      data_q  <= 32'd0;
      tmo_q   <= 24'd0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign o_stb  = stb_q;
  assign o_err  = err_q;
  assign o_data = data_q;
  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rxhexword.sv
// Bench for rxhexword: two instances (upper+timeout, lower-only no timeout) share one byte stream.
// A frame-prefix string model predicts every output each cycle; a vector table checks per-frame outcomes.
module tb_rxhexword;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stb;
  logic [7:0]  byt;
  logic        stb_a, err_a, busy_a;
  logic        stb_b, err_b, busy_b;
  logic [31:0] data_a, data_b;

  rxhexword #(.ACCEPT_UPPER(1'b1), .TIMEOUT(24'd100)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_byte(byt),
    .o_stb(stb_a), .o_data(data_a), .o_err(err_a), .o_busy(busy_a));

  rxhexword #(.ACCEPT_UPPER(1'b0), .TIMEOUT(24'd0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_byte(byt),
    .o_stb(stb_b), .o_data(data_b), .o_err(err_b), .o_busy(busy_b));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the accepted prefix of the frame in progress, per instance.
  string       m_pend [2];
  int          m_idle [2];
  logic [31:0] m_data [2];
  logic        m_stb  [2];
  logic        m_err  [2];
  bit          m_upper[2] = '{1'b1, 1'b0};
  int          m_tmo  [2] = '{100, 0};
  int          cnt_stb[2];
  int          cnt_err[2];

  typedef struct {
    string       txt;
    int          gap;
    int          e_stb_a, e_err_a;
    logic [31:0] e_data_a;
    int          e_stb_b, e_err_b;
    logic [31:0] e_data_b;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic int hexval(byte unsigned c, bit up);
    if (c >= 48 && c <= 57)        return int'(c) - 48;
    if (c >= 97 && c <= 102)       return int'(c) - 87;
    if (up && c >= 65 && c <= 70)  return int'(c) - 55;
    return -1;
  endfunction

  function automatic bit prefix_ok(string s, bit up);
    for (int j = 0; j < s.len(); j++) begin
      byte unsigned c;
      c = s[j];
      case (j)
        0:       if (c != 48) return 1'b0;
        1:       if (!(c == 120 || (up && c == 88))) return 1'b0;
        10:      if (c != 13) return 1'b0;
        11:      if (c != 10) return 1'b0;
        default: if (hexval(c, up) < 0) return 1'b0;
      endcase
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = "";
      m_idle[i] = 0;
      m_data[i] = 32'd0;
      m_stb[i]  = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  task automatic model_step(int i, bit s, byte unsigned b);
    string       cand;
    logic [31:0] w;
    m_stb[i] = 1'b0;
    m_err[i] = 1'b0;
    if (s) begin
      m_idle[i] = 0;
      if (m_pend[i].len() == 0) begin
        if (b == 48) m_pend[i] = "0";
      end else if (!(m_pend[i] == "0" && b == 48)) begin
        cand = {m_pend[i], $sformatf("%c", b)};
        if (prefix_ok(cand, m_upper[i])) begin
          if (cand.len() == 12) begin
            w = 32'd0;
            for (int j = 2; j < 10; j++) w = w * 32'd16 + 32'(hexval(cand[j], m_upper[i]));
            m_data[i] = w;
            m_stb[i]  = 1'b1;
            m_pend[i] = "";
          end else begin
            m_pend[i] = cand;
          end
        end else begin
          m_err[i]  = 1'b1;
          m_pend[i] = (b == 48) ? "0" : "";
        end
      end
    end else if (m_pend[i].len() != 0 && m_tmo[i] != 0) begin
      m_idle[i]++;
      if (m_idle[i] == m_tmo[i]) begin
        m_err[i]  = 1'b1;
        m_pend[i] = "";
        m_idle[i] = 0;
      end
    end
  endtask

  // One clock: drive at negedge, predict, sample at the following negedge.
  task automatic step(bit s, byte unsigned b);
    stb = s;
    byt = s ? b : 8'($urandom);
    for (int i = 0; i < 2; i++) model_step(i, s, b);
    @(posedge clk);
    @(negedge clk);
    checkb("a_stb",  stb_a,  m_stb[0]);
    checkb("a_err",  err_a,  m_err[0]);
    check ("a_data", data_a, m_data[0]);
    checkb("a_busy", busy_a, m_pend[0].len() != 0);
    checkb("b_stb",  stb_b,  m_stb[1]);
    checkb("b_err",  err_b,  m_err[1]);
    check ("b_data", data_b, m_data[1]);
    checkb("b_busy", busy_b, m_pend[1].len() != 0);
    if (stb_a) cnt_stb[0]++;
    if (err_a) cnt_err[0]++;
    if (stb_b) cnt_stb[1]++;
    if (err_b) cnt_err[1]++;
  endtask

  task automatic send_str(string s, int gap);
    for (int j = 0; j < s.len(); j++) begin
      step(1'b1, s[j]);
      repeat (gap) step(1'b0, 8'h00);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      cnt_stb[i] = 0;
      cnt_err[i] = 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[10];
    int    err_at;
    string alpha;
    string fr;

    tbl[0] = '{"0x1234abcd\015\012",    9, 1, 0, 32'h1234abcd, 1, 0, 32'h1234abcd};
    tbl[1] = '{"0XDEADBEEF\015\012",    0, 1, 0, 32'hdeadbeef, 0, 1, 32'h1234abcd};
    tbl[2] = '{"0x12g",                 2, 0, 1, 32'hdeadbeef, 0, 1, 32'h1234abcd};
    tbl[3] = '{"0x00000001\015\012",    1, 1, 0, 32'h00000001, 1, 0, 32'h00000001};
    tbl[4] = '{"0x1230x00000002\015\012", 0, 0, 2, 32'h00000001, 0, 2, 32'h00000001};
    tbl[5] = '{"000x0000000f\015\012",  0, 1, 0, 32'h0000000f, 1, 0, 32'h0000000f};
    tbl[6] = '{"0xCAFEf00d\015\012",    1, 1, 0, 32'hcafef00d, 0, 2, 32'h0000000f};
    tbl[7] = '{"0x123456789\015\012",   0, 0, 1, 32'hcafef00d, 0, 1, 32'h0000000f};
    tbl[8] = '{"0x1234567\015\012",     0, 0, 1, 32'hcafef00d, 0, 1, 32'h0000000f};
    tbl[9] = '{"0x123456780\015\012",   0, 0, 2, 32'hcafef00d, 0, 2, 32'h0000000f};

    rst_n = 1'b0;
    stb   = 1'b0;
    byt   = 8'h00;
    model_reset();
    clr_counts();
    #12;
    checkb("rst_a_stb", stb_a, 1'b0);
    checkb("rst_a_err", err_a, 1'b0);
    check ("rst_a_data", data_a, 32'd0);
    checkb("rst_a_busy", busy_a, 1'b0);
    check ("rst_b_data", data_b, 32'd0);
    checkb("rst_b_busy", busy_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      clr_counts();
      send_str(tbl[k].txt, tbl[k].gap);
      repeat (3) step(1'b0, 8'h00);
      check($sformatf("vec%0d_a_stb_cnt", k), cnt_stb[0], tbl[k].e_stb_a);
      check($sformatf("vec%0d_a_err_cnt", k), cnt_err[0], tbl[k].e_err_a);
      check($sformatf("vec%0d_a_data", k),    data_a,     tbl[k].e_data_a);
      check($sformatf("vec%0d_b_stb_cnt", k), cnt_stb[1], tbl[k].e_stb_b);
      check($sformatf("vec%0d_b_err_cnt", k), cnt_err[1], tbl[k].e_err_b);
      check($sformatf("vec%0d_b_data", k),    data_b,     tbl[k].e_data_b);
    end

    // Stall of exactly TIMEOUT clocks after a digit aborts the frame.
    clr_counts();
    send_str("0x12", 0);
    err_at = -1;
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 8'h00);
      if (err_a && err_at < 0) err_at = k;
    end
    check ("tmo_err_cycle", err_at, 100);
    checkb("tmo_busy_low", busy_a, 1'b0);
    check ("tmo_no_stb", cnt_stb[0], 0);
    check ("tmo_err_cnt", cnt_err[0], 1);
    send_str("z", 0);
    repeat (2) step(1'b0, 8'h00);

    // One clock short of the timeout: the frame survives.
    clr_counts();
    send_str("0x12", 0);
    repeat (99) step(1'b0, 8'h00);
    send_str("345678\015\012", 0);
    repeat (2) step(1'b0, 8'h00);
    check("notmo_err_cnt", cnt_err[0], 0);
    check("notmo_stb_cnt", cnt_stb[0], 1);
    check("notmo_data",    data_a, 32'h12345678);
    check("notmo_b_data",  data_b, 32'h12345678);

    // Asynchronous reset mid-digits.
    send_str("0x1234abcd\015\012", 0);
    step(1'b0, 8'h00);
    check("pre_rst_data", data_a, 32'h1234abcd);
    send_str("0x12", 0);
    stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check ("arst_a_data", data_a, 32'd0);
    checkb("arst_a_busy", busy_a, 1'b0);
    checkb("arst_a_stb",  stb_a,  1'b0);
    checkb("arst_a_err",  err_a,  1'b0);
    check ("arst_b_data", data_b, 32'd0);
    checkb("arst_b_busy", busy_b, 1'b0);
    model_reset();
    clr_counts();
    @(negedge clk);
    rst_n = 1'b1;
    send_str("0xcafef00d\015\012", 0);
    repeat (2) step(1'b0, 8'h00);
    check("post_rst_a_data", data_a, 32'hcafef00d);
    check("post_rst_b_data", data_b, 32'hcafef00d);
    check("post_rst_a_err",  cnt_err[0], 0);

    // Randomized mix of noise, good frames and long stalls.
    alpha = "0xX19afAFg\015\012z";
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: step($urandom_range(0, 1) == 1, alpha[$urandom_range(0, alpha.len() - 1)]);
        3: begin
          if ($urandom_range(0, 1) == 1) fr = {"0x", $sformatf("%08x", $urandom), "\015\012"};
          else                           fr = {"0X", $sformatf("%08X", $urandom), "\015\012"};
          send_str(fr, $urandom_range(0, 3));
        end
        4: repeat ($urandom_range(90, 110)) step(1'b0, 8'h00);
        default: step(1'b0, 8'h00);
      endcase
    end
    repeat (3) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
